// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_if
// Description : Decode-stage / hazard-controller bundle. The decode side
//               (master) presents the instruction sitting in decode together
//               with the X-stage redirect. The controller (slave) returns the
//               stall/flush/issue decisions, the registered bypass selects
//               and the stall counter.
//   dec_valid, dec_rs1/rs2, dec_rs1_used/rs2_used, dec_rd, dec_we,
//   dec_is_load, redirect             : master -> slave
//   stall, flush, issue, fwd_sel_a/b,
//   stall_cnt                         : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    localparam int FSW = $clog2(DEPTH + 1);

    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_rs1_used;
    logic              dec_rs2_used;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_we;
    logic              dec_is_load;
    logic              redirect;

    logic              stall;
    logic              flush;
    logic              issue;
    logic [FSW-1:0]    fwd_sel_a;
    logic [FSW-1:0]    fwd_sel_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_we, dec_is_load, redirect,
        input  stall, flush, issue, fwd_sel_a, fwd_sel_b, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
               dec_rd, dec_we, dec_is_load, redirect,
        output stall, flush, issue, fwd_sel_a, fwd_sel_b, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Parametrised RAW hazard / bypass controller. Tracks the
//               destination of every instruction in the DEPTH post-decode
//               stages (entry 1 = X ... entry DEPTH = WB), picks the youngest
//               in-flight producer for each decode operand, raises a
//               combinational load-use stall and registers per-operand bypass
//               selects that are valid while the consumer is in X.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-low reset
//               hif   - hazard_if slave modport (decode inputs, decisions out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 3,
    parameter int CNT_W      = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    hazard_if.slave   hif
);
    localparam int FSW = $clog2(DEPTH + 1);

    // In-flight writer scoreboard, indexed by stage number.
    logic [DEPTH:1]    r_v;
    logic [DEPTH:1]    r_ld;
    logic [REG_AW-1:0] r_rd [1:DEPTH];

    logic [FSW-1:0]    r_fwd_a;
    logic [FSW-1:0]    r_fwd_b;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_luse_a;
    logic              w_luse_b;
    logic [FSW-1:0]    w_k_a;
    logic [FSW-1:0]    w_k_b;
    logic              w_stall;
    logic              w_issue;
    logic [FSW-1:0]    w_nsel_a;
    logic [FSW-1:0]    w_nsel_b;

    // Producer search. Walking from the oldest tracked stage towards stage 1
    // lets the last hit overwrite earlier ones, so the youngest producer
    // wins. Stage DEPTH is excluded: the regfile writes through, so its
    // value is already visible on the normal read path.
    always_comb begin
        w_hit_a  = 1'b0;
        w_k_a    = '0;
        w_luse_a = 1'b0;
        w_hit_b  = 1'b0;
        w_k_b    = '0;
        w_luse_b = 1'b0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (r_v[k] && (r_rd[k] == hif.dec_rs1) &&
                (hif.dec_rs1 != '0) && hif.dec_rs1_used) begin
                w_hit_a  = 1'b1;
                w_k_a    = FSW'(k);
                // Load data only appears at the output of LOAD_STAGE; the
                // consumer would see this producer at stage k+1 in its X.
                w_luse_a = r_ld[k] && ((k + 1) < LOAD_STAGE);
            end
            if (r_v[k] && (r_rd[k] == hif.dec_rs2) &&
                (hif.dec_rs2 != '0) && hif.dec_rs2_used) begin
                w_hit_b  = 1'b1;
                w_k_b    = FSW'(k);
                w_luse_b = r_ld[k] && ((k + 1) < LOAD_STAGE);
            end
        end
    end

    // Redirect outranks stall: a killed decode slot has nothing to wait for.
    assign w_stall  = hif.dec_valid && !hif.redirect && (w_luse_a || w_luse_b);
    assign w_issue  = hif.dec_valid && !w_stall && !hif.redirect;

    // Selected producer moves one stage further by the time the consumer is
    // in X, hence k+1.
    assign w_nsel_a = (w_issue && w_hit_a) ? (w_k_a + FSW'(1)) : '0;
    assign w_nsel_b = (w_issue && w_hit_b) ? (w_k_b + FSW'(1)) : '0;

    // Scoreboard shift. Non-issued cycles and non-writing instructions both
    // enter as invalid entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_v[1]  <= w_issue && hif.dec_we;
            r_ld[1] <= w_issue && hif.dec_is_load;
            r_rd[1] <= hif.dec_rd;
            for (int k = 2; k <= DEPTH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else begin
            r_fwd_a <= w_nsel_a;
            r_fwd_b <= w_nsel_b;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hif.stall     = w_stall;
    assign hif.flush     = hif.redirect;
    assign hif.issue     = w_issue;
    assign hif.fwd_sel_a = r_fwd_a;
    assign hif.fwd_sel_b = r_fwd_b;
    assign hif.stall_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances: the
//               default configuration (DEPTH=3, LOAD_STAGE=3, CNT_W=16) and a
//               deep one (DEPTH=6, LOAD_STAGE=6, CNT_W=2). A reference model
//               keeps a history of issued instructions with their issue
//               cycle; a producer's stage is its age in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s_valid, s_u1, s_u2, s_we, s_ld, s_redir;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic [1:0] s_en;

    hazard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) if0 ();
    hazard_if #(.REG_AW(5), .DEPTH(6), .CNT_W(2))  if1 ();

    assign if0.dec_valid    = s_valid & s_en[0];
    assign if0.dec_rs1      = s_rs1;
    assign if0.dec_rs2      = s_rs2;
    assign if0.dec_rs1_used = s_u1;
    assign if0.dec_rs2_used = s_u2;
    assign if0.dec_rd       = s_rd;
    assign if0.dec_we       = s_we;
    assign if0.dec_is_load  = s_ld;
    assign if0.redirect     = s_redir;

    assign if1.dec_valid    = s_valid & s_en[1];
    assign if1.dec_rs1      = s_rs1;
    assign if1.dec_rs2      = s_rs2;
    assign if1.dec_rs1_used = s_u1;
    assign if1.dec_rs2_used = s_u2;
    assign if1.dec_rd       = s_rd;
    assign if1.dec_we       = s_we;
    assign if1.dec_is_load  = s_ld;
    assign if1.redirect     = s_redir;

    hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(3), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .reset (rst_n),
        .hif   (if0)
    );

    hazard_ctrl #(.REG_AW(5), .DEPTH(6), .LOAD_STAGE(6), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .hif   (if1)
    );

    int o_stall [2];
    int o_flush [2];
    int o_issue [2];
    int o_fa    [2];
    int o_fb    [2];
    int o_cnt   [2];

    always_comb begin
        o_stall[0] = int'(if0.stall);
        o_flush[0] = int'(if0.flush);
        o_issue[0] = int'(if0.issue);
        o_fa[0]    = int'(if0.fwd_sel_a);
        o_fb[0]    = int'(if0.fwd_sel_b);
        o_cnt[0]   = int'(if0.stall_cnt);
        o_stall[1] = int'(if1.stall);
        o_flush[1] = int'(if1.flush);
        o_issue[1] = int'(if1.issue);
        o_fa[1]    = int'(if1.fwd_sel_a);
        o_fb[1]    = int'(if1.fwd_sel_b);
        o_cnt[1]   = int'(if1.stall_cnt);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_depth [2] = '{3, 6};
    int m_ls    [2] = '{3, 6};
    int m_cmax  [2] = '{65535, 3};

    bit m_val [2][16];
    int m_cyc [2][16];
    bit m_we  [2][16];
    int m_rd  [2][16];
    bit m_ldf [2][16];
    int m_wp  [2];
    int m_now [2];
    int e_fa  [2];
    int e_fb  [2];
    int e_cnt [2];

    // Youngest issued writer of rs that is 1..DEPTH-1 cycles old.
    function automatic void lookup(input int i, input int rs, input bit used,
                                   output int age, output bit ld);
        age = 0;
        ld  = 1'b0;
        for (int e = 0; e < 16; e++) begin
            automatic int a = m_now[i] - m_cyc[i][e];
            if (m_val[i][e] && a >= 1 && a <= m_depth[i] - 1 && m_we[i][e] &&
                m_rd[i][e] == rs && rs != 0 && used && (age == 0 || a < age)) begin
                age = a;
                ld  = m_ldf[i][e];
            end
        end
    endfunction

    always @(negedge clk) begin
        int a1, a2;
        bit l1, l2, v, es, ei;
        for (int i = 0; i < 2; i++) begin
            v = s_valid && s_en[i];
            if (!rst_n) begin
                for (int e = 0; e < 16; e++) m_val[i][e] = 1'b0;
                m_wp[i] = 0; m_now[i] = 0;
                e_fa[i] = 0; e_fb[i] = 0; e_cnt[i] = 0;
                check($sformatf("d%0d rst fwd_a", i), o_fa[i], 0);
                check($sformatf("d%0d rst fwd_b", i), o_fb[i], 0);
                check($sformatf("d%0d rst cnt", i), o_cnt[i], 0);
            end else begin
                lookup(i, int'(s_rs1), s_u1, a1, l1);
                lookup(i, int'(s_rs2), s_u2, a2, l2);
                es = v && !s_redir &&
                     ((a1 > 0 && l1 && a1 + 1 < m_ls[i]) || (a2 > 0 && l2 && a2 + 1 < m_ls[i]));
                ei = v && !es && !s_redir;
                check($sformatf("d%0d stall", i), o_stall[i], int'(es));
                check($sformatf("d%0d flush", i), o_flush[i], int'(s_redir));
                check($sformatf("d%0d issue", i), o_issue[i], int'(ei));
                check($sformatf("d%0d fwd_a", i), o_fa[i], e_fa[i]);
                check($sformatf("d%0d fwd_b", i), o_fb[i], e_fb[i]);
                check($sformatf("d%0d cnt", i), o_cnt[i], e_cnt[i]);
                // state after the coming posedge
                if (ei) begin
                    m_val[i][m_wp[i]] = 1'b1;
                    m_cyc[i][m_wp[i]] = m_now[i];
                    m_we[i][m_wp[i]]  = s_we;
                    m_rd[i][m_wp[i]]  = int'(s_rd);
                    m_ldf[i][m_wp[i]] = s_ld;
                    m_wp[i] = (m_wp[i] + 1) % 16;
                end
                e_fa[i] = (ei && a1 > 0) ? a1 + 1 : 0;
                e_fb[i] = (ei && a2 > 0) ? a2 + 1 : 0;
                if (es && e_cnt[i] < m_cmax[i]) e_cnt[i]++;
                m_now[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int rs1, input int rs2, input bit u1,
                         input bit u2, input int rd, input bit we, input bit ld,
                         input bit redir);
        s_valid = v;  s_rs1 = 5'(rs1); s_rs2 = 5'(rs2);
        s_u1 = u1;    s_u2 = u2;       s_rd = 5'(rd);
        s_we = we;    s_ld = ld;       s_redir = redir;
    endtask

    // Present one instruction and hold it until the selected DUT issues it.
    task automatic instr(input int i, input int rs1, input int rs2, input bit u1,
                         input bit u2, input int rd, input bit we, input bit ld,
                         output int stalls);
        drive(1, rs1, rs2, u1, u2, rd, we, ld, 0);
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_stall[i] == 0) break;
            stalls++;
            @(posedge clk); #1;
        end
        if (stalls >= 20) check("stall_timeout", stalls, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int st;
    int exp_cnt [4] = '{0, 1, 2, 3};

    initial begin
        rst_n = 1'b0;
        s_en  = 2'b01;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // ALU chain
        instr(0, 0, 0, 0, 0, 5, 1, 0, st);
        instr(0, 5, 5, 1, 1, 6, 1, 0, st);
        check("t1 stalls", st, 0);
        @(negedge clk);
        check("t1 fwd_a", o_fa[0], 2);
        check("t1 fwd_b", o_fb[0], 2);
        @(posedge clk); #1;

        // Load-use
        idle(2);
        instr(0, 0, 0, 0, 0, 7, 1, 1, st);
        instr(0, 7, 0, 1, 1, 8, 1, 0, st);
        check("t2 stalls", st, 1);
        @(negedge clk);
        check("t2 fwd_a", o_fa[0], 3);
        check("t2 fwd_b", o_fb[0], 0);
        check("t2 cnt", o_cnt[0], 1);
        @(posedge clk); #1;

        // Double writer: youngest wins
        idle(3);
        instr(0, 0, 0, 0, 0, 5, 1, 0, st);
        instr(0, 0, 0, 1, 0, 5, 1, 0, st);
        instr(0, 5, 0, 1, 0, 12, 1, 0, st);
        @(negedge clk);
        check("t3 fwd_a", o_fa[0], 2);
        @(posedge clk); #1;

        // x0 and unused operands
        idle(3);
        instr(0, 0, 0, 0, 0, 0, 1, 1, st);
        instr(0, 0, 0, 1, 1, 1, 1, 0, st);
        check("t4 x0 stalls", st, 0);
        @(negedge clk);
        check("t4 x0 fwd_a", o_fa[0], 0);
        check("t4 x0 fwd_b", o_fb[0], 0);
        @(posedge clk); #1;
        instr(0, 0, 0, 0, 0, 9, 1, 0, st);
        instr(0, 3, 9, 1, 0, 10, 1, 0, st);
        @(negedge clk);
        check("t4 unused fwd_b", o_fb[0], 0);
        @(posedge clk); #1;

        // Redirect during load-use
        idle(3);
        instr(0, 0, 0, 0, 0, 7, 1, 1, st);
        drive(1, 7, 0, 1, 1, 8, 1, 0, 1);
        @(negedge clk);
        check("t5 stall", o_stall[0], 0);
        check("t5 flush", o_flush[0], 1);
        check("t5 issue", o_issue[0], 0);
        @(posedge clk); #1;
        drive(1, 8, 0, 1, 0, 11, 1, 0, 0);
        @(negedge clk);
        check("t5 next fwd_a", o_fa[0], 0);
        check("t5 next issue", o_issue[0], 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("t5 bubble fwd_a", o_fa[0], 0);
        @(posedge clk); #1;

        // Saturation on the deep instance
        s_en = 2'b10;
        idle(2);
        instr(1, 0, 0, 0, 0, 7, 1, 1, st);
        drive(1, 7, 0, 1, 0, 8, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t6 stall[%0d]", c), o_stall[1], 1);
            check($sformatf("t6 cnt[%0d]", c), o_cnt[1], exp_cnt[c]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t6 issue", o_issue[1], 1);
        check("t6 cnt sat", o_cnt[1], 3);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("t6 fwd_a", o_fa[1], 6);
        @(posedge clk); #1;
        instr(1, 0, 0, 0, 0, 7, 1, 1, st);
        drive(1, 7, 0, 1, 0, 8, 1, 0, 0);
        @(negedge clk);
        check("t6b stall", o_stall[1], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6b cnt hold", o_cnt[1], 3);
        #1 s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t6 async cnt", o_cnt[1], 0);
        check("t6 async fwd_a", o_fa[1], 0);
        check("t6 async stall", o_stall[1], 0);
        check("t6 async cnt0", o_cnt[0], 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        instr(1, 7, 0, 1, 0, 8, 1, 0, st);
        check("t6 post-reset stalls", st, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
